// File: rtl/deserializer.sv
// ---------------------------------------------------------------------------
// deserializer
//   Bit-serial to parallel converter for the FIR filter datapath. Rebuilds
//   LENGTH-bit words from a one-bit-per-enabled-cycle stream, aligned by a
//   frame strobe on the first bit, and presents each completed word through
//   a valid/ready holding register. Overrun and resync events raise sticky
//   error flags.
//
//   Build option: define DESERIALIZER_MSB_FIRST_EN to assemble MSB-first
//   (first bit lands in bit LENGTH-1); default is LSB-first.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_en          bit-rate enable; i_din / i_frame sampled only when high
//   i_frame       high with the first bit of a word
//   i_din         serial data bit
//   i_dout_ready  downstream accepts ov_dout when high with o_dout_valid
//   i_clr_err     synchronous clear of both sticky error flags
//   ov_dout       assembled word, stable while o_dout_valid is high
//   o_dout_valid  holding register full
//   o_busy        word assembly in progress
//   o_overrun     sticky: completed word dropped, holding register was full
//   o_sync_err    sticky: frame arrived mid-word, partial word discarded
// ---------------------------------------------------------------------------
module deserializer #(
  parameter int unsigned LENGTH = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_frame,
  input  logic              i_din,
  input  logic              i_dout_ready,
  input  logic              i_clr_err,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  output logic              o_busy,
  output logic              o_overrun,
  output logic              o_sync_err
);

  localparam int unsigned CW = $clog2(LENGTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Only LENGTH-1 bits of history are stored: the final bit of a word is
  // taken straight from i_din when the word completes, so the bit that a
  // full-width shift register would push out is never needed.
  logic [LENGTH-2:0] hist_q, hist_d, hist_base;
  logic [LENGTH-1:0] word;
  logic              capture, restart, word_done, sync_set;
  logic              load, overrun_set;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and bit-count control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    restart   = 1'b0;
    word_done = 1'b0;
    sync_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_en && i_frame) begin
          capture = 1'b1;
          restart = 1'b1;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (i_en) begin
          capture = 1'b1;
          if (i_frame) begin
            // Resync: drop the partial word and start over with this bit
            restart  = 1'b1;
            sync_set = 1'b1;
            cnt_d    = CW'(1);
          end else if (cnt_q == CW'(LENGTH - 1)) begin
            word_done = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and handshake decisions
  always_comb begin
    o_busy      = (state_q == SHIFT);
    load        = word_done && (!o_dout_valid || i_dout_ready);
    overrun_set = word_done && o_dout_valid && !i_dout_ready;
  end

  // Shift path: a restart shifts into cleared history
  always_comb begin
    hist_base = restart ? '0 : hist_q;
`ifdef DESERIALIZER_MSB_FIRST_EN
    word   = {hist_base, i_din};
    hist_d = word[LENGTH-2:0];
`else
    word   = {i_din, hist_base};
    hist_d = word[LENGTH-1:1];
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      hist_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (capture) hist_q <= hist_d;
    end
  end

  // Holding register and sticky flags; a new error event beats a clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ov_dout      <= '0;
      o_dout_valid <= 1'b0;
      o_overrun    <= 1'b0;
      o_sync_err   <= 1'b0;
    end else begin
      if (load) begin
        ov_dout      <= word;
        o_dout_valid <= 1'b1;
      end else if (o_dout_valid && i_dout_ready) begin
        o_dout_valid <= 1'b0;
      end
      if (overrun_set)    o_overrun <= 1'b1;
      else if (i_clr_err) o_overrun <= 1'b0;
      if (sync_set)       o_sync_err <= 1'b1;
      else if (i_clr_err) o_sync_err <= 1'b0;
    end
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Bit-serial to parallel converter for the FIR filter datapath; consumes the single-bit stream produced by the serializer stage (LSB first, one bit per enabled cycle) and rebuilds LENGTH-bit words.
- Word alignment comes from a frame strobe on the first bit.
- Completed words are presented through a valid/ready holding register to the downstream parallel stage.
- Overrun and resync conditions are flagged with sticky error bits.

Parameters:
- LENGTH, 24, word width in bits; legal range 2..64.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_en  in  1  bit-rate enable; i_din and i_frame are sampled only when high.
- i_frame  in  1  high with the first (LSB) bit of a word.
- i_din  in  1  serial data bit.
- i_dout_ready  in  1  downstream accepts ov_dout when high with o_dout_valid.
- i_clr_err  in  1  synchronous clear of both sticky error flags.
- ov_dout  out  LENGTH  assembled word; stable while o_dout_valid is high.
- o_dout_valid  out  1  holding register full.
- o_busy  out  1  high while in state SHIFT.
- o_overrun  out  1  sticky: completed word dropped because the holding register was full.
- o_sync_err  out  1  sticky: i_frame arrived mid-word; the partial word was discarded.

Behaviour:
- Reset (async assert, sync deassert is the integrator's job):
  - State IDLE, bit count 0, shift register 0.
  - ov_dout 0, o_dout_valid 0, o_busy 0, o_overrun 0, o_sync_err 0.
- Bit count width is clog2(LENGTH+1); it holds the number of bits captured in the current word.
- Shift register: on each accepted bit, shift_reg <= {i_din, shift_reg[LENGTH-1:1]}. After LENGTH bits, bit 0 holds the first bit received.
- Cycles with i_en=0 change nothing in the shift path. The output handshake still operates on every cycle.
- IDLE state:
  - i_en & i_frame: capture the bit, count=1, go to SHIFT.
  - i_en & !i_frame: ignore the bit and stay in IDLE; this is not an error.
- SHIFT state, i_en & !i_frame:
  - Capture the bit and increment count.
  - If this is bit number LENGTH, run a word-complete event, reset count to 0, and go to IDLE.
- SHIFT state, i_en & i_frame (any count, including the last-bit position):
  - Set o_sync_err.
  - Discard the partial word.
  - Capture this bit as bit 1 of a new word (count=1) and stay in SHIFT.
- Word-complete event:
  - Load the new word (shifted value including the current bit) into ov_dout and set o_dout_valid=1 when either:
    - o_dout_valid=0, or
    - o_dout_valid & i_dout_ready are both high in the same cycle (simultaneous consume and load: valid stays 1, new data appears).
  - Otherwise set o_overrun; ov_dout and o_dout_valid are unchanged and the new word is lost.
- Handshake:
  - A transfer occurs when o_dout_valid & i_dout_ready.
  - o_dout_valid falls on the next edge unless a load occurs on that same edge.
  - ov_dout only changes on a load.
- Latency: o_dout_valid rises on the edge that samples bit LENGTH. The word is visible the cycle after its last bit.
- Back-to-back words: i_frame on the cycle immediately after the last bit is accepted from IDLE with no gap. Sustained throughput is one word per LENGTH enabled cycles.
- i_clr_err clears both flags. If a clear coincides with a new error event, the set wins.
- Reset mid-word discards all state with no flag set.

Optional Feature:
- Macro: DESERIALIZER_MSB_FIRST_EN.
- Defined: the shift direction reverses, shift_reg <= {shift_reg[LENGTH-2:0], i_din}. The first bit received lands in bit LENGTH-1; this pairs with an MSB-first serializer.
- Undefined: LSB-first as specified above.
- All other behaviour, including timing and flags, is identical in both builds.

Test Plan:
- LENGTH=8, i_en=1 continuously, frame then bits of 0xA5 LSB-first -> ov_dout=0xA5, o_dout_valid=1 on the edge after bit 8, o_busy low afterwards.
- 0x3C then 0xC3 back-to-back, i_dout_ready=1 -> two transfers 8 cycles apart, o_dout_valid stays high across the reload, no error flags.
- i_dout_ready=0, send 0x11 then 0x22 -> ov_dout stays 0x11, o_overrun=1. Assert i_clr_err -> o_overrun=0.
- i_en toggling 1/0 every cycle while sending 0x5A -> ov_dout=0x5A after 16 clock cycles. Bits are sampled only on enabled cycles.
- Frame, 3 bits, then frame plus a full 0x81 -> o_sync_err=1, ov_dout=0x81, partial bits absent.
- Assert i_rst after 4 bits of a word, release, send 0xFF -> all outputs 0 during reset, then ov_dout=0xFF with no error flags.
